decoder_3to8_pulse_seq: RTL and testbench
=========================================

// Module: decoder_3to8_pulse_seq
// PURPOSE
//  Inverse of the 8-to-3 priority encoder. Accepts 3-bit codes y, each qualified by valid f.
//  Buffers the codes in a small FIFO.
//  For each code, drives the matching one-hot line of x[7:0] for HOLD cycles.
//  Inserts exactly one all-zero gap cycle between consecutive pulses.
//  Sits downstream of the encoder and re-expands its (y,f) stream into timed one-hot strobes.
// PARAMETERS
//  HOLD   4   cycles each one-hot pulse stays high; legal 1..15
//  DEPTH  2   FIFO entries; power of two, legal 2..8
// PORTS
//  clk      in   1   clock, rising edge
//  rst      in   1   asynchronous reset, active-high
//  y        in   3   code to decode (0..7)
//  f        in   1   y valid; transfer when f && ready
//  ready    out  1   FIFO can accept; = !full (combinational from FIFO count)
//  x        out  8   registered one-hot output; 8'h00 when no pulse is active
//  busy     out  1   state != IDLE || FIFO not empty
//  err      out  1   sticky: a code was offered (f=1) while ready=0 and was dropped
//  err_clr  in   1   synchronous clear of err
// BEHAVIOUR
//  Reset (async, immediate): x=8'h00, err=0, FIFO flushed, count=0, ready=1, busy=0, state=IDLE.
//  Reset mid-pulse: x drops to 0 without waiting for a clock; queued codes are lost.
//  FIFO
//   - push on f && ready; pop is driven by the FSM.
//   - ready follows the count at the start of the cycle, so push is never accepted when full.
//   - A pop at a clock edge frees a slot, visible as ready=1 in the next cycle.
//   - Simultaneous push and pop when not full is allowed; count is unchanged.
//   - Read/write pointers wrap modulo DEPTH.
//  Decode: x <= 8'b1 << code; code 0 -> 8'h01, code 7 -> 8'h80.
//  FSM states: IDLE, DRIVE, GAP; 4-bit down-counter cnt.
//   IDLE:  if FIFO not empty -> pop; x<=onehot(head); cnt<=HOLD-1; go DRIVE. Else x=0, stay.
//   DRIVE: x held. If cnt==0 -> x<=0, go GAP; else cnt<=cnt-1.
//   GAP:   x=0 for this cycle. If FIFO not empty -> pop, load x and cnt, go DRIVE; else go IDLE.
//  Timing
//   - Pulse width = exactly HOLD cycles. Separation between back-to-back pulses = exactly 1 zero cycle.
//   - Latency: code accepted at edge N into an empty FIFO in IDLE -> x valid after edge N+1.
//   - A code pushed at the same edge a GAP pop would occur is not seen until the next cycle.
//   - HOLD=1: DRIVE lasts one cycle; pulses alternate 1 high / 1 zero.
//   - Never more than one bit of x is high.
//  err
//   - Set at any edge where f && !ready.
//   - Cleared by err_clr; set wins if both occur in the same cycle.
//   - Unaffected by FSM state.
// TESTING
//  1 Reset: assert rst mid-pulse (x=8'h08) -> x=8'h00 with no clock edge; ready=1, busy=0, err=0.
//  2 Single code: y=5,f=1 for 1 cycle, HOLD=4
//    -> x=8'h20 for exactly 4 cycles starting 2 cycles after f; then 8'h00; busy falls.
//  3 Back-to-back: y=0,1,7 on 3 consecutive cycles (DEPTH=2)
//    -> third code is accepted only if ready=1, else err=1;
//       accepted codes give 8'h01 x4, 0 x1, 8'h02 x4, 0 x1, ...
//  4 Overflow: hold FIFO full, f=1 with y=3 -> ready=0, err=1 stays high;
//    err_clr with f=0 -> err=0; err_clr together with overflow -> err stays 1.
//  5 HOLD=1: stream codes 2,4,6 -> x = 04,00,10,00,40,00.
//  6 Exhaustive decode: each code 0..7 -> x equals 1<<code; popcount(x) <= 1 every cycle (assertion).

Source files
------------

// File: rtl/decoder_3to8_pulse_seq.sv
// decoder_3to8_pulse_seq
//   Re-expands a (code, valid) stream into timed one-hot strobes. Codes are
//   buffered in a small FIFO. Each code drives its one-hot line of x for HOLD
//   cycles, and exactly one all-zero cycle separates back-to-back pulses.
// Parameters
//   HOLD    : cycles each one-hot pulse stays high (1..15)
//   DEPTH   : FIFO entries, power of two (2..8)
// Ports
//   clk     : clock, rising edge
//   rst     : asynchronous reset, active-high
//   y       : 3-bit code to decode
//   f       : y valid; transfer when f && ready
//   ready   : FIFO can accept (combinational from FIFO count)
//   x       : registered one-hot output, 8'h00 when no pulse is active
//   busy    : FSM not idle or FIFO not empty
//   err     : sticky, a code was offered while ready=0 and was dropped
//   err_clr : synchronous clear of err
module decoder_3to8_pulse_seq #(
    parameter int unsigned HOLD  = 4,
    parameter int unsigned DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] y,
    input  logic       f,
    output logic       ready,
    output logic [7:0] x,
    output logic       busy,
    output logic       err,
    input  logic       err_clr
);

    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW    = AW + 1;
    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    logic [2:0]       r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_x;
    logic             r_err;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [2:0]       w_head;
    logic [7:0]       w_onehot;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [7:0]       w_x_nxt;

    // FIFO status uses the count at the start of the cycle, so a full FIFO
    // never accepts even if the FSM pops at the same edge.
    assign w_full   = (r_count == CW'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_push   = f && !w_full;
    assign w_head   = r_mem[r_rptr];
    assign w_onehot = 8'(8'h01 << w_head);

    assign ready = !w_full;
    assign x     = r_x;
    assign busy  = (r_state != S_IDLE) || !w_empty;
    assign err   = r_err;

    // Storage array; validity is tracked by pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= y;
        end
    end

    // FIFO pointers and occupancy; pointers wrap modulo DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FSM state, hold counter and output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_x     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_x     <= w_x_nxt;
        end
    end

    // Next-state logic; IDLE and GAP both start a new pulse when a code waits.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_x_nxt     = r_x;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE, S_GAP: begin
                w_x_nxt = '0;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_x_nxt     = w_onehot;
                    w_cnt_nxt   = CNT_W'(HOLD - 1);
                    w_state_nxt = S_DRIVE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DRIVE: begin
                if (r_cnt == '0) begin
                    w_x_nxt     = '0;
                    w_state_nxt = S_GAP;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_x_nxt     = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Sticky drop flag; a new drop wins over a clear in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (f && w_full) begin
            r_err <= 1'b1;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decoder_3to8_pulse_seq.sv
// tb_decoder_3to8_pulse_seq
//   Scoreboard bench for decoder_3to8_pulse_seq. Two instances: HOLD=4 and
//   HOLD=1, both DEPTH=2, sharing clock, reset, y and err_clr. The driver
//   pushes hand-computed expected pulses into a queue; a monitor pops one
//   entry per observed pulse and checks value, width, latency and gap.
module tb_decoder_3to8_pulse_seq;

    localparam int unsigned H0 = 4;
    localparam int unsigned H1 = 1;

    typedef struct {
        logic [7:0] x;
        int         issue;
        int         lat;
        int         gap;
    } sb_t;

    logic       clk;
    logic       rst;
    logic [2:0] y;
    logic       f0, f1;
    logic       err_clr;
    logic       ready0, ready1;
    logic [7:0] x0, x1;
    logic       busy0, busy1;
    logic       err0, err1;
    logic       sel;

    logic       rdy_m, busy_m, err_m;

    int  n_checks = 0;
    int  n_fail   = 0;
    int  cyc      = 0;
    sb_t sb[$];

    bit         in_pulse = 0;
    int         run      = 0;
    int         zrun     = -1;
    logic [7:0] cur      = '0;
    sb_t        mon_e;

    logic [7:0] exp_tab [8];

    decoder_3to8_pulse_seq #(.HOLD(H0), .DEPTH(2)) u_dut0 (
        .clk    (clk),
        .rst    (rst),
        .y      (y),
        .f      (f0),
        .ready  (ready0),
        .x      (x0),
        .busy   (busy0),
        .err    (err0),
        .err_clr(err_clr)
    );

    decoder_3to8_pulse_seq #(.HOLD(H1), .DEPTH(2)) u_dut1 (
        .clk    (clk),
        .rst    (rst),
        .y      (y),
        .f      (f1),
        .ready  (ready1),
        .x      (x1),
        .busy   (busy1),
        .err    (err1),
        .err_clr(err_clr)
    );

    assign rdy_m  = sel ? ready1 : ready0;
    assign busy_m = sel ? busy1  : busy0;
    assign err_m  = sel ? err1   : err0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One stimulus cycle: drive inputs, check status seen this cycle, and
    // record the expected pulse when ex is non-zero (code accepted).
    task automatic drive(input bit f_i, input logic [2:0] y_i, input bit clr_i,
                         input int e_rdy, input int e_err, input int e_busy,
                         input logic [7:0] ex, input int lat, input int gap);
        sb_t e;
        @(negedge clk);
        y       = y_i;
        err_clr = clr_i;
        f0      = f_i && !sel;
        f1      = f_i && sel;
        if (e_rdy  >= 0) chk("ready", int'(rdy_m),  e_rdy);
        if (e_err  >= 0) chk("err",   int'(err_m),  e_err);
        if (e_busy >= 0) chk("busy",  int'(busy_m), e_busy);
        if (ex != 8'h00) begin
            e.x     = ex;
            e.issue = cyc;
            e.lat   = lat;
            e.gap   = gap;
            sb.push_back(e);
        end
    endtask

    task automatic wait_idle(input int limit);
        bit done = 1'b0;
        @(negedge clk);
        f0      = 1'b0;
        f1      = 1'b0;
        err_clr = 1'b0;
        for (int i = 0; i < limit && !done; i++) begin
            #1;
            if (!busy_m && sb.size() == 0 && !in_pulse) done = 1'b1;
            else @(negedge clk);
        end
        chk("idle_timeout", int'(done), 1);
    endtask

    task automatic set_sel(input bit s);
        @(posedge clk);
        #1 sel = s;
    endtask

    // Monitor: one scoreboard entry per pulse on the selected instance.
    always @(negedge clk) begin
        logic [7:0] mx;
        int         hold;
        mx   = sel ? x1 : x0;
        hold = sel ? int'(H1) : int'(H0);
        chk("onehot0_x0", int'($countones(x0) <= 1), 1);
        chk("onehot0_x1", int'($countones(x1) <= 1), 1);
        if (rst) begin
            sb.delete();
            in_pulse = 1'b0;
            zrun     = -1;
        end else if (mx != 8'h00) begin
            if (!in_pulse) begin
                in_pulse = 1'b1;
                run      = 1;
                cur      = mx;
                if (sb.size() == 0) begin
                    chk("unexpected_pulse", int'(mx), 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("pulse_value", int'(mx), int'(mon_e.x));
                    if (mon_e.lat >= 0) chk("latency", cyc - mon_e.issue, mon_e.lat);
                    if (mon_e.gap >= 0) chk("gap", zrun, mon_e.gap);
                end
            end else begin
                run++;
                chk("pulse_stable", int'(mx), int'(cur));
            end
        end else begin
            if (in_pulse) begin
                chk("pulse_width", run, hold);
                in_pulse = 1'b0;
                zrun     = 1;
            end else if (zrun >= 0) begin
                zrun++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        rst     = 1'b1;
        sel     = 1'b0;
        y       = 3'd0;
        f0      = 1'b0;
        f1      = 1'b0;
        err_clr = 1'b0;

        // Reset state
        #3;
        chk("rst_x0",     int'(x0),     0);
        chk("rst_x1",     int'(x1),     0);
        chk("rst_ready0", int'(ready0), 1);
        chk("rst_busy0",  int'(busy0),  0);
        chk("rst_err0",   int'(err0),   0);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;

        // Single code 5: 8'h20 for 4 cycles, busy falls one cycle after the gap
        drive(1'b1, 3'd5, 1'b0, 1, 0, 0, 8'h20, 2, -1);
        for (int i = 0; i < 6; i++) drive(1'b0, 3'd0, 1'b0, 1, 0, 1, 8'h00, -1, -1);
        drive(1'b0, 3'd0, 1'b0, 1, 0, 0, 8'h00, -1, -1);

        // Back-to-back 0,1,7: all accepted since the first pop frees a slot
        drive(1'b1, 3'd0, 1'b0, 1, 0, 0, 8'h01, 2, -1);
        drive(1'b1, 3'd1, 1'b0, 1, 0, 1, 8'h02, -1, 1);
        drive(1'b1, 3'd7, 1'b0, 1, 0, 1, 8'h80, -1, 1);
        wait_idle(40);
        drive(1'b0, 3'd0, 1'b0, 1, 0, 0, 8'h00, -1, -1);

        // Exhaustive decode on both instances
        for (int s = 0; s < 2; s++) begin
            set_sel(s[0]);
            for (int c = 0; c < 8; c++) begin
                drive(1'b1, 3'(c), 1'b0, 1, 0, 0, exp_tab[c], 2, -1);
                wait_idle(30);
            end
        end

        // HOLD=1 stream 2,4,6 -> 04,00,10,00,40,00
        drive(1'b1, 3'd2, 1'b0, 1, 0, 0, 8'h04, 2, -1);
        drive(1'b1, 3'd4, 1'b0, 1, 0, 1, 8'h10, -1, 1);
        drive(1'b1, 3'd6, 1'b0, 1, 0, 1, 8'h40, -1, 1);
        wait_idle(30);
        set_sel(1'b0);

        // Overflow and err handling on the HOLD=4 instance
        drive(1'b1, 3'd3, 1'b0, 1, 0, 0, 8'h08, 2, -1);
        drive(1'b1, 3'd3, 1'b0, 1, 0, 1, 8'h08, -1, 1);
        drive(1'b1, 3'd3, 1'b0, 1, 0, 1, 8'h08, -1, 1);
        drive(1'b1, 3'd3, 1'b0, 0, 0, 1, 8'h00, -1, -1);
        drive(1'b0, 3'd3, 1'b1, 0, 1, 1, 8'h00, -1, -1);
        drive(1'b1, 3'd3, 1'b1, 0, 0, 1, 8'h00, -1, -1);
        drive(1'b0, 3'd3, 1'b0, 0, 1, 1, 8'h00, -1, -1);
        drive(1'b0, 3'd3, 1'b0, 1, 1, 1, 8'h00, -1, -1);
        chk("x_mid_pulse", int'(x0), 8'h08);

        // Reset mid-pulse: outputs clear without a clock edge
        #2 rst = 1'b1;
        #1;
        chk("async_rst_x",     int'(x0),     0);
        chk("async_rst_ready", int'(ready0), 1);
        chk("async_rst_busy",  int'(busy0),  0);
        chk("async_rst_err",   int'(err0),   0);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        drive(1'b0, 3'd0, 1'b0, 1, 0, 0, 8'h00, -1, -1);
        wait_idle(10);
        for (int i = 0; i < 6; i++) drive(1'b0, 3'd0, 1'b0, 1, 0, 0, 8'h00, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
